tl_tlp_assembler: RTL and testbench

Transaction-layer stage directly downstream of the header generator. Accepts one 128-bit TLP header plus sideband attributes, and drains the matching payload from the write-data path. Emits the TLP as a 64-bit beat stream with sop/eop/keep toward the data link layer. Headers are released one at a time, and the next header may be accepted on the eop beat, so back-to-back TLPs incur no bubble.

---
 rtl/tl_pkg.sv | 24 ++
 rtl/tl_tlp_assembler.sv | 154 +++++++++++++++
 tb/tb_tl_tlp_assembler.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared transaction-layer types: beat geometry, assembler FSM states and
// the registered output beat.
package tl_pkg;

  localparam int TL_HDR_BEATS   = 2;
  localparam int TL_DW_PER_BEAT = 2;
  localparam int TL_BEAT_W      = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    H0   = 2'd1,
    H1   = 2'd2,
    PLD  = 2'd3
  } tl_asm_state_e;

  typedef struct packed {
    logic [TL_BEAT_W-1:0] data;
    logic                 sop;
    logic                 eop;
    logic [1:0]           keep;
    logic                 posted;
  } tl_tlp_beat_t;

endpackage

// File: rtl/tl_tlp_assembler.sv
// Serialises one 128-bit TLP header plus its payload into 64-bit sop/eop/keep
// beats; a new header can be taken on the eop transfer for bubble-free streaming.
module tl_tlp_assembler
  import tl_pkg::*;
#(
  parameter int DATA_W            = 64,
  parameter int MAX_PAYLOAD_BYTES = 256,
  parameter int LEN_W             = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [127:0]      hdr_i,
  input  logic              hdr_valid_i,
  output logic              hdr_ready_o,
  input  logic              hdr_has_data_i,
  input  logic [LEN_W-1:0]  hdr_len_dw_i,
  input  logic              hdr_posted_i,
  input  logic [DATA_W-1:0] pld_data_i,
  input  logic              pld_valid_i,
  output logic              pld_ready_o,
  output logic [DATA_W-1:0] tlp_data_o,
  output logic              tlp_valid_o,
  input  logic              tlp_ready_i,
  output logic              tlp_sop_o,
  output logic              tlp_eop_o,
  output logic [1:0]        tlp_keep_o,
  output logic              tlp_posted_o,
  output logic              err_len_o
);

  localparam int MAX_DW = MAX_PAYLOAD_BYTES / 4;
  localparam int CNT_W  = $clog2(MAX_PAYLOAD_BYTES / 8 + 1);

  tl_asm_state_e    state_reg, state_next;
  tl_tlp_beat_t     beat_reg, beat_next;
  logic             valid_reg, valid_next;
  logic [63:0]      hdr_hi_reg, hdr_hi_next;
  logic [CNT_W-1:0] rem_reg, rem_next;
  logic             odd_reg, odd_next;
  logic             err_reg, err_next;

  logic             can_load;
  logic             hdr_fire;
  logic             pld_fire;
  logic             len_illegal;
  logic [LEN_W:0]   len_round;
  logic [CNT_W-1:0] len_beats;

  // The output register may be refilled when empty or when its beat leaves this cycle.
  assign can_load    = !valid_reg || tlp_ready_i;
  assign hdr_ready_o = rst_n && ((state_reg == IDLE) || (valid_reg && beat_reg.eop && tlp_ready_i));
  assign pld_ready_o = ((state_reg == H1) || (state_reg == PLD)) && (rem_reg != '0) && can_load;
  assign hdr_fire    = hdr_valid_i && hdr_ready_o;
  assign pld_fire    = pld_valid_i && pld_ready_o;

  assign len_illegal = hdr_has_data_i &&
                       ((hdr_len_dw_i == '0) || (hdr_len_dw_i > LEN_W'(MAX_DW)));
  assign len_round   = {1'b0, hdr_len_dw_i} + (LEN_W+1)'(TL_DW_PER_BEAT - 1);
  assign len_beats   = CNT_W'(len_round / (LEN_W+1)'(TL_DW_PER_BEAT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (hdr_fire) begin
      state_next = H0;
    end else if (can_load) begin
      case (state_reg)
        H0:      state_next = H1;
        H1:      state_next = beat_reg.eop ? IDLE : PLD;
        PLD:     state_next = (valid_reg && beat_reg.eop) ? IDLE : PLD;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    beat_next   = beat_reg;
    valid_next  = valid_reg;
    hdr_hi_next = hdr_hi_reg;
    rem_next    = rem_reg;
    odd_next    = odd_reg;
    err_next    = hdr_fire && len_illegal;
    if (hdr_fire) begin
      beat_next   = '{data: hdr_i[63:0], sop: 1'b1, eop: 1'b0, keep: 2'b11,
                      posted: hdr_posted_i};
      valid_next  = 1'b1;
      hdr_hi_next = hdr_i[127:64];
      rem_next    = (hdr_has_data_i && !len_illegal) ? len_beats : '0;
      odd_next    = hdr_len_dw_i[0];
    end else if (can_load) begin
      case (state_reg)
        H0: begin
          beat_next.data = hdr_hi_reg;
          beat_next.sop  = 1'b0;
          beat_next.eop  = (rem_reg == '0);
          beat_next.keep = 2'b11;
          valid_next     = 1'b1;
        end
        H1, PLD: begin
          if (pld_fire) begin
            beat_next.data = pld_data_i;
            beat_next.sop  = 1'b0;
            beat_next.eop  = (rem_reg == CNT_W'(1));
            beat_next.keep = ((rem_reg == CNT_W'(1)) && odd_reg) ? 2'b01 : 2'b11;
            valid_next     = 1'b1;
            rem_next       = rem_reg - CNT_W'(1);
          end else begin
            // Empty slot: either the TLP just ended or payload is late.
            beat_next.sop = 1'b0;
            beat_next.eop = 1'b0;
            valid_next    = 1'b0;
          end
        end
        default: begin
          valid_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_reg   <= '0;
      valid_reg  <= 1'b0;
      hdr_hi_reg <= '0;
      rem_reg    <= '0;
      odd_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      beat_reg   <= beat_next;
      valid_reg  <= valid_next;
      hdr_hi_reg <= hdr_hi_next;
      rem_reg    <= rem_next;
      odd_reg    <= odd_next;
      err_reg    <= err_next;
    end
  end

  assign tlp_data_o   = beat_reg.data;
  assign tlp_valid_o  = valid_reg;
  assign tlp_sop_o    = beat_reg.sop;
  assign tlp_eop_o    = beat_reg.eop;
  assign tlp_keep_o   = beat_reg.keep;
  assign tlp_posted_o = beat_reg.posted;
  assign err_len_o    = err_reg;

endmodule

// File: tb/tb_tl_tlp_assembler.sv
// Bench for tl_tlp_assembler: directed scenarios plus randomized traffic,
// each compared against a spec-level beat list model.
module tb_tl_tlp_assembler;

  localparam int LEN_W  = 10;
  localparam int MAX_DW = 64;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  keep;
    logic        posted;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] hdr_i = '0;
  logic         hdr_valid_i = 1'b0;
  logic         hdr_ready_o;
  logic         hdr_has_data_i = 1'b0;
  logic [LEN_W-1:0] hdr_len_dw_i = '0;
  logic         hdr_posted_i = 1'b0;
  logic [63:0]  pld_data_i = '0;
  logic         pld_valid_i = 1'b0;
  logic         pld_ready_o;
  logic [63:0]  tlp_data_o;
  logic         tlp_valid_o;
  logic         tlp_ready_i = 1'b1;
  logic         tlp_sop_o;
  logic         tlp_eop_o;
  logic [1:0]   tlp_keep_o;
  logic         tlp_posted_o;
  logic         err_len_o;

  tl_tlp_assembler dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_i(hdr_i), .hdr_valid_i(hdr_valid_i), .hdr_ready_o(hdr_ready_o),
    .hdr_has_data_i(hdr_has_data_i), .hdr_len_dw_i(hdr_len_dw_i), .hdr_posted_i(hdr_posted_i),
    .pld_data_i(pld_data_i), .pld_valid_i(pld_valid_i), .pld_ready_o(pld_ready_o),
    .tlp_data_o(tlp_data_o), .tlp_valid_o(tlp_valid_o), .tlp_ready_i(tlp_ready_i),
    .tlp_sop_o(tlp_sop_o), .tlp_eop_o(tlp_eop_o), .tlp_keep_o(tlp_keep_o),
    .tlp_posted_o(tlp_posted_o), .err_len_o(err_len_o)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    err_pulses = 0;
  int    pld_ready_seen = 0;
  bit    rand_ready = 1'b0;
  bit    feed_en = 1'b1;
  int    pld_gap = 0;
  bit    pld_take = 1'b0;
  beat_t exp_q[$];
  beat_t got_q[$];
  int    got_cyc[$];
  logic [63:0] pld_q[$];

  // Monitor: log every transferred beat, error pulses and payload-ready cycles.
  always @(negedge clk) begin
    cyc++;
    pld_take = pld_valid_i && pld_ready_o;
    if (rst_n) begin
      if (tlp_valid_o && tlp_ready_i) begin
        beat_t b;
        b.data = tlp_data_o; b.sop = tlp_sop_o; b.eop = tlp_eop_o;
        b.keep = tlp_keep_o; b.posted = tlp_posted_o;
        got_q.push_back(b);
        got_cyc.push_back(cyc);
      end
      if (err_len_o) err_pulses++;
      if (pld_ready_o) pld_ready_seen++;
    end
  end

  // Payload source with optional random gaps.
  always @(posedge clk) begin
    #1;
    if (pld_take && pld_q.size() != 0) void'(pld_q.pop_front());
    pld_take = 1'b0;
    if (feed_en && pld_q.size() != 0 && $urandom_range(0, 99) >= pld_gap) begin
      pld_valid_i = 1'b1;
      pld_data_i  = pld_q[0];
    end else begin
      pld_valid_i = 1'b0;
      pld_data_i  = '0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) tlp_ready_i = ($urandom_range(0, 3) != 0);
  end

  // Reference model: the beat list a TLP must produce; returns 1 for an illegal length.
  function automatic bit add_tlp(input logic [127:0] h, input bit hd, input int len,
                                 input bit posted);
    bit    legal;
    int    n;
    beat_t b;
    logic [63:0] w;
    legal = hd && (len >= 1) && (len <= MAX_DW);
    n = legal ? (len + 1) / 2 : 0;
    b = '{data: h[63:0], sop: 1'b1, eop: 1'b0, keep: 2'b11, posted: posted};
    exp_q.push_back(b);
    b = '{data: h[127:64], sop: 1'b0, eop: (n == 0), keep: 2'b11, posted: posted};
    exp_q.push_back(b);
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      pld_q.push_back(w);
      b = '{data: w, sop: 1'b0, eop: (i == n - 1),
            keep: ((i == n - 1) && (len % 2 == 1)) ? 2'b01 : 2'b11, posted: posted};
      exp_q.push_back(b);
    end
    return hd && !legal;
  endfunction

  task automatic send_hdr(input logic [127:0] h, input bit hd, input int len,
                          input bit posted, output bit illegal);
    int n = 0;
    illegal        = add_tlp(h, hd, len, posted);
    hdr_i          = h;
    hdr_has_data_i = hd;
    hdr_len_dw_i   = LEN_W'(len);
    hdr_posted_i   = posted;
    hdr_valid_i    = 1'b1;
    @(negedge clk);
    while (!hdr_ready_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL hdr_accept timeout got ready=%b exp ready=1", hdr_ready_o);
    end
    @(posedge clk); #1;
    hdr_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s drain timeout got %0d beats exp %0d", name, got_q.size(), exp_q.size());
    end
  endtask

  task automatic clear_queues();
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({tlp_valid_o, tlp_sop_o, tlp_eop_o, tlp_keep_o, tlp_posted_o, err_len_o,
         pld_ready_o, hdr_ready_o, tlp_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v%b s%b e%b k%b p%b err%b pr%b hr%b d%h exp all 0",
               tlp_valid_o, tlp_sop_o, tlp_eop_o, tlp_keep_o, tlp_posted_o, err_len_o,
               pld_ready_o, hdr_ready_o, tlp_data_o);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (hdr_ready_o !== 1'b1 || tlp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got hdr_ready=%b valid=%b exp 1/0", hdr_ready_o, tlp_valid_o);
    end
  endtask

  task automatic test_mrd();
    logic [127:0] h = 128'h11111111_11111111_22222222_22222222;
    bit ill;
    @(posedge clk); #1;
    tlp_ready_i = 1'b1; pld_ready_seen = 0; err_pulses = 0;
    send_hdr(h, 1'b0, 5, 1'b0, ill);
    @(negedge clk);
    checks++;
    if (tlp_valid_o !== 1'b1 || tlp_sop_o !== 1'b1 || tlp_eop_o !== 1'b0 ||
        tlp_data_o !== h[63:0] || tlp_keep_o !== 2'b11) begin
      errors++;
      $display("FAIL mrd_beat0 got v%b s%b e%b k%b d%h exp v1 s1 e0 k11 d%h",
               tlp_valid_o, tlp_sop_o, tlp_eop_o, tlp_keep_o, tlp_data_o, h[63:0]);
    end
    @(negedge clk);
    checks++;
    if (tlp_valid_o !== 1'b1 || tlp_sop_o !== 1'b0 || tlp_eop_o !== 1'b1 ||
        tlp_data_o !== h[127:64] || tlp_keep_o !== 2'b11) begin
      errors++;
      $display("FAIL mrd_beat1 got v%b s%b e%b k%b d%h exp v1 s0 e1 k11 d%h",
               tlp_valid_o, tlp_sop_o, tlp_eop_o, tlp_keep_o, tlp_data_o, h[127:64]);
    end
    wait_drain("mrd");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL mrd_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL mrd_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (pld_ready_seen != 0 || err_pulses != 0) begin
      errors++;
      $display("FAIL mrd_side got pld_ready_cycles=%0d err=%0d exp 0/0", pld_ready_seen, err_pulses);
    end
    clear_queues();
  endtask

  task automatic test_mwr();
    bit ill;
    @(posedge clk); #1;
    send_hdr({$urandom, $urandom, $urandom, $urandom}, 1'b1, 3, 1'b1, ill);
    wait_drain("mwr");
    checks++;
    if (got_q.size() != 4 || exp_q.size() != 4) begin
      errors++; $display("FAIL mwr_count got %0d exp 4", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL mwr_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (got_cyc.size() == 4 && got_cyc[3] != got_cyc[0] + 3) begin
      errors++; $display("FAIL mwr_gapless got span %0d exp 3", got_cyc[3] - got_cyc[0]);
    end
    clear_queues();
  endtask

  task automatic test_backpressure();
    logic [127:0] h = {$urandom, $urandom, $urandom, $urandom};
    bit ill;
    @(posedge clk); #1;
    send_hdr(h, 1'b1, 4, 1'b0, ill);
    @(posedge clk); #1;
    tlp_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (tlp_valid_o !== 1'b1 || tlp_data_o !== h[127:64] || tlp_sop_o !== 1'b0 ||
          tlp_eop_o !== 1'b0 || pld_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v%b d%h s%b e%b pr%b exp v1 d%h s0 e0 pr0", k,
                 tlp_valid_o, tlp_data_o, tlp_sop_o, tlp_eop_o, pld_ready_o, h[127:64]);
      end
    end
    @(posedge clk); #1;
    tlp_ready_i = 1'b1;
    wait_drain("bp");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    clear_queues();
  endtask

  task automatic test_starvation();
    logic [63:0] w0;
    bit ill;
    @(posedge clk); #1;
    feed_en = 1'b0;
    send_hdr({$urandom, $urandom, $urandom, $urandom}, 1'b1, 4, 1'b1, ill);
    w0 = pld_q[0];
    repeat (3) @(negedge clk);
    checks++;
    if (tlp_valid_o !== 1'b0) begin
      errors++; $display("FAIL starve_bubble0 got valid=%b exp 0", tlp_valid_o);
    end
    feed_en = 1'b1;
    @(negedge clk);
    checks++;
    if (tlp_valid_o !== 1'b0) begin
      errors++; $display("FAIL starve_bubble1 got valid=%b exp 0", tlp_valid_o);
    end
    @(negedge clk);
    checks++;
    if (tlp_valid_o !== 1'b1 || tlp_sop_o !== 1'b0 || tlp_data_o !== w0) begin
      errors++;
      $display("FAIL starve_resume got v%b s%b d%h exp v1 s0 d%h", tlp_valid_o, tlp_sop_o,
               tlp_data_o, w0);
    end
    wait_drain("starve");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL starve_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL starve_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    clear_queues();
  endtask

  task automatic test_back_to_back();
    bit ill;
    @(posedge clk); #1;
    send_hdr({$urandom, $urandom, $urandom, $urandom}, 1'b1, 2, 1'b1, ill);
    send_hdr({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 1'b0, ill);
    wait_drain("b2b");
    checks++;
    if (got_q.size() != 5 || exp_q.size() != 5) begin
      errors++; $display("FAIL b2b_count got %0d exp 5", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (got_cyc.size() == 5 && got_cyc[3] != got_cyc[2] + 1) begin
      errors++; $display("FAIL b2b_nobubble got gap %0d exp 1", got_cyc[3] - got_cyc[2]);
    end
    clear_queues();
  endtask

  task automatic test_illegal();
    int lens[2] = '{0, 65};
    bit ill;
    foreach (lens[j]) begin
      @(posedge clk); #1;
      err_pulses = 0; pld_ready_seen = 0;
      pld_q.push_back(64'hDEAD_BEEF_0BAD_F00D);
      send_hdr({$urandom, $urandom, $urandom, $urandom}, 1'b1, lens[j], 1'b1, ill);
      @(negedge clk);
      checks++;
      if (err_len_o !== 1'b1) begin
        errors++; $display("FAIL illegal%0d_err got %b exp 1", lens[j], err_len_o);
      end
      @(negedge clk);
      checks++;
      if (err_len_o !== 1'b0 || tlp_eop_o !== 1'b1 || tlp_sop_o !== 1'b0) begin
        errors++;
        $display("FAIL illegal%0d_h1 got err%b eop%b sop%b exp err0 eop1 sop0", lens[j],
                 err_len_o, tlp_eop_o, tlp_sop_o);
      end
      wait_drain("illegal");
      checks++;
      if (got_q.size() != 2 || exp_q.size() != 2 || got_q[1] !== exp_q[1] ||
          got_q[0] !== exp_q[0]) begin
        errors++; $display("FAIL illegal%0d_stream got %0d beats exp 2", lens[j], got_q.size());
      end
      checks++;
      if (err_pulses != 1 || pld_ready_seen != 0 || pld_q.size() != 1 || !ill) begin
        errors++;
        $display("FAIL illegal%0d_side got err=%0d pld_ready=%0d left=%0d exp 1/0/1", lens[j],
                 err_pulses, pld_ready_seen, pld_q.size());
      end
      pld_q.delete();
      clear_queues();
    end
  endtask

  task automatic test_random();
    int exp_err = 0;
    bit ill;
    int r, len;
    @(posedge clk); #1;
    err_pulses = 0; rand_ready = 1'b1; pld_gap = 30;
    for (int t = 0; t < 40; t++) begin
      r   = $urandom_range(0, 9);
      len = (r == 0) ? 0 : (r == 1) ? $urandom_range(65, 1023) : $urandom_range(1, 64);
      send_hdr({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), len,
               1'($urandom_range(0, 1)), ill);
      if (ill) exp_err++;
    end
    wait_drain("random");
    rand_ready = 1'b0; pld_gap = 0;
    @(posedge clk); #1;
    tlp_ready_i = 1'b1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (err_pulses != exp_err) begin
      errors++; $display("FAIL rand_err got %0d exp %0d", err_pulses, exp_err);
    end
    clear_queues();
  endtask

  task automatic test_reset_mid();
    int eops = 0;
    bit ill;
    @(posedge clk); #1;
    send_hdr({$urandom, $urandom, $urandom, $urandom}, 1'b1, 8, 1'b1, ill);
    repeat (3) @(negedge clk);
    checks++;
    if (tlp_valid_o !== 1'b1 || tlp_sop_o !== 1'b0 || tlp_eop_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_pld got v%b s%b e%b exp v1 s0 e0", tlp_valid_o,
                         tlp_sop_o, tlp_eop_o);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({tlp_valid_o, tlp_sop_o, tlp_eop_o, tlp_keep_o, tlp_posted_o, err_len_o,
         pld_ready_o, hdr_ready_o, tlp_data_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_clear got v%b s%b e%b k%b p%b pr%b hr%b d%h exp all 0",
               tlp_valid_o, tlp_sop_o, tlp_eop_o, tlp_keep_o, tlp_posted_o, pld_ready_o,
               hdr_ready_o, tlp_data_o);
    end
    foreach (got_q[i]) if (got_q[i].eop) eops++;
    checks++;
    if (eops != 0) begin
      errors++; $display("FAIL rstmid_eop got %0d eop beats exp 0", eops);
    end
    pld_q.delete(); pld_take = 1'b0;
    clear_queues();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (hdr_ready_o !== 1'b1 || tlp_valid_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_release got hdr_ready=%b valid=%b exp 1/0",
                         hdr_ready_o, tlp_valid_o);
    end
    @(posedge clk); #1;
    send_hdr({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1, 1'b0, ill);
    wait_drain("recover");
    checks++;
    if (got_q.size() != 3 || exp_q.size() != 3 || got_q[2] !== exp_q[2]) begin
      errors++; $display("FAIL recover_stream got %0d beats exp 3", got_q.size());
    end
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_mrd();
    test_mwr();
    test_backpressure();
    test_starvation();
    test_back_to_back();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
